vga_timing_receiver: RTL

VGA_TIMING_RECEIVER -- requirements
Module: vga_timing_receiver

---
 rtl/vga_timing_pkg.sv | 14 +
 rtl/vga_timing_receiver_if.sv | 23 ++
 rtl/vga_edge_det.sv | 21 ++
 rtl/vga_timing_receiver.sv | 114 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and the lock FSM state type.
// Shared by the receiver and the sync generator so both agree on one timing set.
package vga_timing_pkg;
  localparam int H_TOTAL_DEF = 800;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_TOTAL_DEF = 525;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int LOCK_FRAMES_DEF = 2;
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_e;
endpackage

// File: rtl/vga_timing_receiver_if.sv
// vga_timing_receiver_if: pin-side inputs and recovered-pixel outputs of the VGA receiver.
// master = video source / consumer side, slave = receiver.
interface vga_timing_receiver_if;
  logic       pix_en;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] rgb_in;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       pix_valid;
  logic [2:0] rgb_out;
  logic       frame_start;
  logic       locked;
  logic [7:0] err_count;
  modport master (
    output pix_en, hsync_in, vsync_in, rgb_in,
    input  pix_x, pix_y, pix_valid, rgb_out, frame_start, locked, err_count
  );
  modport slave (
    input  pix_en, hsync_in, vsync_in, rgb_in,
    output pix_x, pix_y, pix_valid, rgb_out, frame_start, locked, err_count
  );
endinterface

// File: rtl/vga_edge_det.sv
// vga_edge_det: samples an active-low sync on pixel strobes and flags its falling edge.
// Ports: clock, reset_n (async, active-low), en_i pixel strobe, d_i sync pin, fall_o edge seen on this strobe.
module vga_edge_det (
  input  logic clock,
  input  logic reset_n,
  input  logic en_i,
  input  logic d_i,
  output logic fall_o
);
  logic cur_q, prev_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_q <= 1'b1;
      prev_q <= 1'b1;
    end else if (en_i) begin
      cur_q <= d_i;
      prev_q <= cur_q;
    end
  end
  assign fall_o = en_i && prev_q && !cur_q;
endmodule

// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver: recovers pixel coordinates and colour from VGA sync/rgb pins and tracks timing lock.
// Ports: clock, reset_n (async, active-low); bus (slave): pix_en/hsync_in/vsync_in/rgb_in in,
// pix_x/pix_y/pix_valid/rgb_out/frame_start/locked/err_count out.
module vga_timing_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input logic clock,
  input logic reset_n,
  vga_timing_receiver_if.slave bus
);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0] GOOD_LOCK = 8'(LOCK_FRAMES);
  state_e     state_q;
  logic       hfall, vfall, line_err, frame_err, err, show;
  logic [2:0] rgb_s_q, rgb_out_q;
  logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d, pix_x_q, pix_x_d;
  logic [8:0] pix_y_q, pix_y_d;
  logic [7:0] good_q, good_d, err_q;
  logic       pix_valid_q, frame_start_q, locked_q;
  vga_edge_det u_hs (.clock(clock), .reset_n(reset_n), .en_i(bus.pix_en), .d_i(bus.hsync_in), .fall_o(hfall));
  vga_edge_det u_vs (.clock(clock), .reset_n(reset_n), .en_i(bus.pix_en), .d_i(bus.vsync_in), .fall_o(vfall));
  always_comb begin
    // a missing hsync is flagged once, on the strobe where hcount saturates
    line_err = hfall ? hcount_q != H_LAST : bus.pix_en && hcount_q == 10'd1022;
    frame_err = vfall && vcount_q != V_LAST;
    err = line_err || frame_err;
    hcount_d = hfall ? '0 : hcount_q + {9'd0, hcount_q != 10'h3ff};
    vcount_d = vfall ? '0 : vcount_q + {9'd0, hfall};
    // hcount/vcount here describe the pixel currently held in rgb_s_q
    show = state_q == LOCKED && hcount_q >= H_START && hcount_q < H_END
           && vcount_q >= V_START && vcount_q < V_END;
    pix_x_d = hcount_q - H_START;
    pix_y_d = 9'(vcount_q - V_START);
    good_d = good_q + 8'd1;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      hcount_q <= '0;
      vcount_q <= '0;
      good_q <= '0;
      err_q <= '0;
      rgb_s_q <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      rgb_out_q <= '0;
      pix_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      if (bus.pix_en) begin
        rgb_s_q <= bus.rgb_in;
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
        // coincident line and frame errors count once; SEARCH errors are expected noise
        if (err && state_q != SEARCH && err_q != 8'hff) err_q <= err_q + 8'd1;
        case (state_q)
          SEARCH: if (vfall) begin
            state_q <= CHECK;
            good_q <= '0;
          end
          CHECK: if (err) begin
            state_q <= SEARCH;
          end else if (vfall) begin
            good_q <= good_d;
            if (good_d == GOOD_LOCK) begin
              state_q <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: if (err) begin
            state_q <= SEARCH;
            locked_q <= 1'b0;
          end
          default: begin
            state_q <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
        if (show) begin
          pix_x_q <= pix_x_d;
          pix_y_q <= pix_y_d;
          rgb_out_q <= rgb_s_q;
          pix_valid_q <= 1'b1;
          frame_start_q <= pix_x_d == '0 && pix_y_d == '0;
        end
      end
    end
  end
  assign bus.pix_x = pix_x_q;
  assign bus.pix_y = pix_y_q;
  assign bus.rgb_out = rgb_out_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.locked = locked_q;
  assign bus.err_count = err_q;
endmodule
